// File: rtl/lift_pkg.sv
// lift_pkg: shared floor encodings, direction values and dispatcher states for the lift call path.
package lift_pkg;
  localparam int DEF_NUM_FLOORS = 3;
  localparam logic [2:0] FLOOR_0 = 3'b001;
  localparam logic [2:0] FLOOR_1 = 3'b010;
  localparam logic [2:0] FLOOR_2 = 3'b100;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  typedef enum logic [1:0] {IDLE, SERVE, DOOR_HOLD, FAULT} state_t;
endpackage

// File: rtl/lift_call_select.sv
// lift_call_select: combinational SCAN picker returning the next one-hot target and travel direction.
module lift_call_select #(
  parameter int NUM_FLOORS = 3
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [NUM_FLOORS-1:0] cur_floor,
  input  logic                  dir,
  output logic [NUM_FLOORS-1:0] target,
  output logic                  new_dir,
  output logic                  found
);
  import lift_pkg::*;
  logic [NUM_FLOORS-1:0] above, below, near_up, near_dn;
  logic hit, use_up;
  always_comb begin
    above = '0;
    below = '0;
    near_up = '0;
    near_dn = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      below[i] = pending[i] & ~hit & ~cur_floor[i];
      above[i] = pending[i] & hit;
      hit = hit | cur_floor[i];
    end
    // ascending overwrite keeps the highest below; descending keeps the lowest above
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below[i]) near_dn = NUM_FLOORS'(1) << i;
      if (above[NUM_FLOORS-1-i]) near_up = NUM_FLOORS'(1) << (NUM_FLOORS-1-i);
    end
    use_up = (dir == DIR_UP) ? |above : ~|below;
    target = use_up ? near_up : near_dn;
    new_dir = use_up ? DIR_UP : DIR_DOWN;
    found = |(above | below);
  end
endmodule

// File: rtl/lift_call_dispatcher.sv
// lift_call_dispatcher: latches floor calls, dispatches them in SCAN order and guards each request with a watchdog.
// Optional LIFT_TRIP_CNT_EN adds a saturating trip_count_o of accepted completions.
module lift_call_dispatcher #(
  parameter int NUM_FLOORS       = lift_pkg::DEF_NUM_FLOORS,
  parameter int DOOR_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_FLOORS-1:0] call_btn_i,
  input  logic [NUM_FLOORS-1:0] out_current_floor,
  input  logic                  complete,
  output logic [NUM_FLOORS-1:0] request_floor,
  output logic                  req_valid,
  output logic                  over_time,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  busy_o
`ifdef LIFT_TRIP_CNT_EN
  , output logic [15:0]         trip_count_o
`endif
);
  import lift_pkg::*;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HOLD_W = (DOOR_HOLD_CYCLES > 1) ? $clog2(DOOR_HOLD_CYCLES) : 1;
  state_t state, state_n;
  logic [NUM_FLOORS-1:0] pending_r, target_r, sel_target, clr;
  logic dir_r, sel_dir, sel_found;
  logic [WD_W-1:0] wd_r;
  logic [HOLD_W-1:0] hold_r;
  logic dispatch, accept, timeout, hold_done, at_cur_call;

  lift_call_select #(.NUM_FLOORS(NUM_FLOORS)) u_select (
    .pending   (pending_r),
    .cur_floor (out_current_floor),
    .dir       (dir_r),
    .target    (sel_target),
    .new_dir   (sel_dir),
    .found     (sel_found)
  );

  always_comb begin
    dispatch = (state == IDLE) && $onehot(out_current_floor) && sel_found;
    accept = (state == SERVE) && complete && (out_current_floor == target_r);
    timeout = (state == SERVE) && (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
    hold_done = hold_r == HOLD_W'(DOOR_HOLD_CYCLES - 1);
    at_cur_call = |(call_btn_i & out_current_floor);
    // calls at the floor the car is parked on are absorbed rather than dispatched
    clr = (accept ? target_r : '0) |
          (((state == IDLE) || (state == DOOR_HOLD)) ? out_current_floor : '0);
    state_n = state;
    unique case (state)
      IDLE:      state_n = dispatch ? SERVE : IDLE;
      SERVE:     state_n = accept ? DOOR_HOLD : (timeout ? FAULT : SERVE);
      DOOR_HOLD: state_n = (hold_done && !at_cur_call) ? IDLE : DOOR_HOLD;
      default:   state_n = FAULT;
    endcase
    request_floor = (state == SERVE) ? target_r : '0;
    req_valid = state == SERVE;
    over_time = state == FAULT;
    busy_o = (state == SERVE) || (state == DOOR_HOLD);
    pending_o = pending_r;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      pending_r <= '0;
      target_r <= '0;
      dir_r <= DIR_UP;
      wd_r <= '0;
      hold_r <= '0;
    end else begin
      state <= state_n;
      pending_r <= (pending_r | call_btn_i) & ~clr;
      if (dispatch) begin
        target_r <= sel_target;
        dir_r <= sel_dir;
      end
      wd_r <= ((state == SERVE) && !accept) ? wd_r + WD_W'(1) : '0;
      hold_r <= ((state == DOOR_HOLD) && !hold_done && !at_cur_call) ? hold_r + HOLD_W'(1) : '0;
    end
  end

`ifdef LIFT_TRIP_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) trip_count_o <= '0;
    else if (accept && (trip_count_o != 16'hFFFF)) trip_count_o <= trip_count_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lift_call_dispatcher.sv
// tb_lift_call_dispatcher: directed vector table plus randomized run against a floor-index reference model.
module tb_lift_call_dispatcher;
  import lift_pkg::*;
  localparam int TMO = 64;
  localparam int HOLD = 4;

  typedef struct packed {
    logic       rst;
    logic [2:0] btn;
    logic [2:0] cur;
    logic       cmp;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;
  logic [2:0] call_btn_i, out_current_floor, request_floor, pending_o;
  logic complete, req_valid, over_time, busy_o;
`ifdef LIFT_TRIP_CNT_EN
  logic [15:0] trip_count;
`endif
  int checks = 0;
  int failures = 0;
  vec_t tab_a[$];
  vec_t tab_b[$];

  int m_st;
  logic [2:0] m_pend;
  int m_tgt;
  bit m_up;
  int m_wait, m_hold;
  logic rr, rk;
  logic [2:0] rb, rc;
  int cmp_pct;

  lift_call_dispatcher dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .call_btn_i        (call_btn_i),
    .out_current_floor (out_current_floor),
    .complete          (complete),
    .request_floor     (request_floor),
    .req_valid         (req_valid),
    .over_time         (over_time),
    .pending_o         (pending_o),
    .busy_o            (busy_o)
`ifdef LIFT_TRIP_CNT_EN
    , .trip_count_o    (trip_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_out();
    return {request_floor, req_valid, over_time, pending_o, busy_o};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [8:0] exp);
    logic [8:0] act;
    act = dut_out();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got req/v/ot/pend/busy=%b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] b, input logic [2:0] c, input logic k);
    rst_i = r;
    call_btn_i = b;
    out_current_floor = c;
    complete = k;
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input string nm, input int idx, input vec_t v);
    step(v.rst, v.btn, v.cur, v.cmp);
    chk(nm, idx, v.exp);
  endtask

  // Reference model: states as plain ints (0 idle, 1 serving, 2 door hold, 3 fault), target as a floor index.
  task automatic model_step(input logic r, input logic [2:0] b, input logic [2:0] c, input logic k);
    int ci, up_i, dn_i;
    logic acc;
    logic [2:0] clr;
    if (!r) begin
      m_st = 0; m_pend = 3'b000; m_up = 1'b1; m_wait = 0; m_hold = 0; m_tgt = 0;
      return;
    end
    ci = -1;
    for (int f = 0; f < 3; f++) if (c == 3'(1 << f)) ci = f;
    acc = (m_st == 1) && k && (c == 3'(1 << m_tgt));
    clr = acc ? 3'(1 << m_tgt) : 3'b000;
    if (m_st == 0 || m_st == 2) clr = clr | c;
    case (m_st)
      0: if (ci >= 0) begin
        up_i = -1;
        dn_i = -1;
        for (int f = ci + 1; f < 3; f++) if (m_pend[f] && up_i < 0) up_i = f;
        for (int f = ci - 1; f >= 0; f--) if (m_pend[f] && dn_i < 0) dn_i = f;
        if (up_i >= 0 && (m_up || dn_i < 0)) begin
          m_tgt = up_i; m_up = 1'b1; m_st = 1; m_wait = 0;
        end else if (dn_i >= 0) begin
          m_tgt = dn_i; m_up = 1'b0; m_st = 1; m_wait = 0;
        end
      end
      1: if (acc) begin
        m_st = 2; m_hold = 0; m_wait = 0;
      end else if (m_wait == TMO - 1) m_st = 3;
      else m_wait++;
      2: if (|(b & c)) m_hold = 0;
      else if (m_hold == HOLD - 1) m_st = 0;
      else m_hold++;
      default: ;
    endcase
    m_pend = (m_pend | b) & ~clr;
  endtask

  function automatic logic [8:0] model_exp();
    return {(m_st == 1) ? 3'(1 << m_tgt) : 3'b000, m_st == 1, m_st == 3, m_pend, (m_st == 1) || (m_st == 2)};
  endfunction

  initial begin
    tab_a = '{
      '{1'b0, 3'b111, 3'b001, 1'b0, 9'b000_0_0_000_0},
      '{1'b0, 3'b111, 3'b001, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b100, 3'b001, 1'b0, 9'b000_0_0_100_0},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b100_1_0_100_1},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b100_1_0_100_1},
      '{1'b1, 3'b000, 3'b100, 1'b1, 9'b000_0_0_000_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_000_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_000_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_000_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b001, 3'b001, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b101, 3'b010, 1'b0, 9'b000_0_0_101_0},
      '{1'b1, 3'b000, 3'b010, 1'b0, 9'b100_1_0_101_1},
      '{1'b1, 3'b000, 3'b100, 1'b1, 9'b000_0_0_001_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_001_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_001_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_001_1},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b000_0_0_001_0},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b001_1_0_001_1},
      '{1'b1, 3'b000, 3'b010, 1'b1, 9'b001_1_0_001_1},
      '{1'b1, 3'b000, 3'b001, 1'b1, 9'b000_0_0_000_1},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b000_0_0_000_1},
      '{1'b1, 3'b001, 3'b001, 1'b0, 9'b000_0_0_000_1},
      '{1'b1, 3'b100, 3'b001, 1'b0, 9'b000_0_0_100_1},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b000_0_0_100_1},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b000_0_0_100_1},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b000_0_0_100_0},
      '{1'b1, 3'b000, 3'b001, 1'b0, 9'b100_1_0_100_1}
    };
    tab_b = '{
      '{1'b1, 3'b010, 3'b001, 1'b0, 9'b000_0_1_110_0},
      '{1'b1, 3'b000, 3'b010, 1'b1, 9'b000_0_1_110_0},
      '{1'b0, 3'b000, 3'b001, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b001, 3'b100, 1'b0, 9'b000_0_0_001_0},
      '{1'b1, 3'b000, 3'b100, 1'b0, 9'b001_1_0_001_1},
      '{1'b0, 3'b000, 3'b100, 1'b0, 9'b000_0_0_000_0},
      '{1'b1, 3'b101, 3'b010, 1'b0, 9'b000_0_0_101_0},
      '{1'b1, 3'b000, 3'b010, 1'b0, 9'b100_1_0_101_1}
    };

    rst_i = 1'b0;
    call_btn_i = 3'b000;
    out_current_floor = FLOOR_0;
    complete = 1'b0;

    foreach (tab_a[i]) run_row("dir_a", i, tab_a[i]);
    // request to floor 2 stays outstanding without completion until the watchdog trips
    for (int i = 0; i < TMO - 1; i++) begin
      step(1'b1, 3'b000, FLOOR_0, 1'b0);
      chk("wd_wait", i, 9'b100_1_0_100_1);
    end
    step(1'b1, 3'b000, FLOOR_0, 1'b0);
    chk("wd_trip", 0, 9'b000_0_1_100_0);
    foreach (tab_b[i]) run_row("dir_b", i, tab_b[i]);

    model_step(1'b0, 3'b000, FLOOR_0, 1'b0);
    step(1'b0, 3'b000, FLOOR_0, 1'b0);
    chk("rand_rst", 0, model_exp());
    cmp_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) cmp_pct = (($urandom_range(0, 2) == 0) ? 2 : (($urandom_range(0, 1) == 0) ? 30 : 70));
      rr = ($urandom_range(0, 199) != 0);
      rb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 19) == 0) rc = 3'($urandom_range(0, 7));
      else if (m_st == 1 && $urandom_range(0, 9) < 7) rc = 3'(1 << m_tgt);
      else rc = 3'(1 << $urandom_range(0, 2));
      rk = ($urandom_range(0, 99) < cmp_pct);
      model_step(rr, rb, rc, rk);
      step(rr, rb, rc, rk);
      chk("rand", n, model_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
